clk_cal_ctl: RTL

Parametrised single-clock calibration controller for a tap-selectable ring oscillator. It measures the oscillator's divided output against a reference-clock window and drives a thermometer tap enable toward a target count. Coarse acquisition uses an optional successive-approximation search; fine acquisition is ±1 tracking with tolerance-based lock detection. It sits between the oscillator's enable bus and system configuration, running entirely on `ref_clk`.

---
 rtl/clk_cal_pkg.sv | 23 ++
 rtl/clk_cal_ctl_if.sv | 31 +++
 rtl/freq_meter.sv | 47 ++++
 rtl/clk_cal_ctl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clk_cal_pkg.sv
// rtl/clk_cal_pkg.sv - status and FSM state encodings shared by the calibration controller
package clk_cal_pkg;

    localparam int STATUS_W = 3;
    localparam int STATE_W  = 2;

    typedef enum logic [STATUS_W-1:0] {
        STAT_IDLE      = 3'd0,
        STAT_SEARCH    = 3'd1,
        STAT_TRACK     = 3'd2,
        STAT_LOCKED    = 3'd3,
        STAT_FAIL_FAST = 3'd4,
        STAT_FAIL_SLOW = 3'd5
    } cal_status_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_EVAL    = 2'd3
    } cal_state_e;

endpackage

// File: rtl/clk_cal_ctl_if.sv
// rtl/clk_cal_ctl_if.sv - configuration and oscillator-control bus of clk_cal_ctl
interface clk_cal_ctl_if
    import clk_cal_pkg::*;
#(
    parameter int TAP_W = 9,
    parameter int CNT_W = 16,
    parameter int TOL_W = 8
) ();

    logic                  enable;
    logic [CNT_W-1:0]      ref_window;
    logic [CNT_W-1:0]      target;
    logic [TOL_W-1:0]      tolerance;
    logic [TAP_W-1:0]      init;
    logic [2**TAP_W-1:0]   en;
    logic [TAP_W-1:0]      tap;
    logic [CNT_W-1:0]      measured;
    logic                  meas_valid;
    logic [STATUS_W-1:0]   status;

    modport master (
        output enable, ref_window, target, tolerance, init,
        input  en, tap, measured, meas_valid, status
    );

    modport slave (
        input  enable, ref_window, target, tolerance, init,
        output en, tap, measured, meas_valid, status
    );

endinterface

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - synchronises osc_div and counts its rising edges over a ref_clk window
module freq_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             osc_div,
    input  logic             start,
    input  logic [CNT_W-1:0] window,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] last_idx;
    logic             edge_seen;

    // start is a level: counters are held clear whenever no window is open
    always_comb begin
        sync_d     = {sync_q[1:0], osc_div};
        edge_seen  = sync_q[1] & ~sync_q[2];
        last_idx   = (window == '0) ? '0 : window - CNT_W'(1);
        count      = (edge_seen && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        done       = start && (win_cnt_q == last_idx);
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        if (start && !done) begin
            win_cnt_d  = win_cnt_q + CNT_W'(1);
            edge_cnt_d = count;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= '0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/clk_cal_ctl.sv
// rtl/clk_cal_ctl.sv - ring-oscillator tap calibration FSM; CLK_CAL_SAR_EN adds coarse SAR search
module clk_cal_ctl
    import clk_cal_pkg::*;
#(
    parameter int TAP_W    = 9,
    parameter int CNT_W    = 16,
    parameter int TOL_W    = 8,
    parameter int SETTLE_N = 8,
    parameter int LOCK_N   = 4
) (
    input  logic          ref_clk,
    input  logic          resetn,
    input  logic          osc_div,
    clk_cal_ctl_if.slave  bus
);

    localparam int EN_W  = 2**TAP_W;
    localparam int SET_W = $clog2(SETTLE_N + 1);
    localparam int LCK_W = $clog2(LOCK_N + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = '1;
`ifdef CLK_CAL_SAR_EN
    localparam int BIT_W = (TAP_W > 1) ? $clog2(TAP_W) : 1;
    logic [BIT_W-1:0] sar_bit_q, sar_bit_d;
`endif

    cal_state_e       state_q, state_d;
    cal_status_e      status_q, status_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [EN_W-1:0]  en_q, en_d;
    logic [CNT_W-1:0] measured_q, measured_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] win_q, win_d, target_q, target_d;
    logic [TOL_W-1:0] tol_q, tol_d;
    logic [CNT_W-1:0] meas_count;
    logic             meas_done, meas_run, fast, slow;

    // one extra bit so target + tolerance and measured + tolerance never wrap
    assign fast     = {1'b0, measured_q} > ({1'b0, target_q} + (CNT_W+1)'(tol_q));
    assign slow     = ({1'b0, measured_q} + (CNT_W+1)'(tol_q)) < {1'b0, target_q};
    assign meas_run = (state_q == ST_MEASURE);

    freq_meter #(.CNT_W(CNT_W)) u_meter (
        .clk     (ref_clk),
        .resetn  (resetn),
        .osc_div (osc_div),
        .start   (meas_run),
        .window  (win_q),
        .count   (meas_count),
        .done    (meas_done)
    );

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        settle_cnt_d = settle_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        tap_d        = tap_q;
        measured_d   = measured_q;
        meas_valid_d = 1'b0;
        win_d        = win_q;
        target_d     = target_q;
        tol_d        = tol_q;
`ifdef CLK_CAL_SAR_EN
        sar_bit_d    = sar_bit_q;
`endif
        if (!bus.enable) begin
            state_d    = ST_IDLE;
            status_d   = STAT_IDLE;
            lock_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                    lock_cnt_d   = '0;
`ifdef CLK_CAL_SAR_EN
                    tap_d            = '0;
                    tap_d[TAP_W-1]   = 1'b1;
                    sar_bit_d        = BIT_W'(TAP_W - 1);
                    status_d         = STAT_SEARCH;
`else
                    tap_d    = bus.init;
                    status_d = STAT_TRACK;
`endif
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SET_W'(SETTLE_N - 1)) begin
                        state_d  = ST_MEASURE;
                        win_d    = bus.ref_window;
                        target_d = bus.target;
                        tol_d    = bus.tolerance;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (meas_done) begin
                        measured_d   = meas_count;
                        meas_valid_d = 1'b1;
                        state_d      = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
`ifdef CLK_CAL_SAR_EN
                    if (status_q == STAT_SEARCH) begin
                        if (!fast) tap_d[sar_bit_q] = 1'b0;
                        if (sar_bit_q == '0) begin
                            status_d = STAT_TRACK;
                        end else begin
                            tap_d[sar_bit_q - BIT_W'(1)] = 1'b1;
                            sar_bit_d = sar_bit_q - BIT_W'(1);
                        end
                    end else
`endif
                    if (fast) begin
                        lock_cnt_d = '0;
                        if (tap_q == TAP_MAX) status_d = STAT_FAIL_FAST;
                        else begin
                            tap_d    = tap_q + TAP_W'(1);
                            status_d = STAT_TRACK;
                        end
                    end else if (slow) begin
                        lock_cnt_d = '0;
                        if (tap_q == '0) status_d = STAT_FAIL_SLOW;
                        else begin
                            tap_d    = tap_q - TAP_W'(1);
                            status_d = STAT_TRACK;
                        end
                    end else begin
                        if (lock_cnt_q != LCK_W'(LOCK_N)) lock_cnt_d = lock_cnt_q + LCK_W'(1);
                        status_d = (lock_cnt_q >= LCK_W'(LOCK_N - 1)) ? STAT_LOCKED : STAT_TRACK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        en_d = '0;
        for (int i = 0; i < EN_W; i++) en_d[i] = (TAP_W'(i) <= tap_d);
    end

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            status_q     <= STAT_IDLE;
            settle_cnt_q <= '0;
            lock_cnt_q   <= '0;
            tap_q        <= '1;
            en_q         <= '1;
            measured_q   <= '0;
            meas_valid_q <= 1'b0;
            win_q        <= '0;
            target_q     <= '0;
            tol_q        <= '0;
`ifdef CLK_CAL_SAR_EN
            sar_bit_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            settle_cnt_q <= settle_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            tap_q        <= tap_d;
            en_q         <= en_d;
            measured_q   <= measured_d;
            meas_valid_q <= meas_valid_d;
            win_q        <= win_d;
            target_q     <= target_d;
            tol_q        <= tol_d;
`ifdef CLK_CAL_SAR_EN
            sar_bit_q    <= sar_bit_d;
`endif
        end
    end

    assign bus.en         = en_q;
    assign bus.tap        = tap_q;
    assign bus.measured   = measured_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.status     = status_q;

endmodule
